// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg -- one registered pipeline stage: valid bit, PC and NLANE
// independent operand lanes, with flush (bubble insertion) and stall (hold).
//
// Priority on each rising clk edge: rst > flush > stall > load.
//   flush : out_valid<=0, lanes<=0, pc_out<=pc_in (FLUSH_KEEP_PC=1) or 0
//   stall : everything holds
//   load  : out_valid<=in_valid, pc_out<=pc_in, lanes<=in_valid ? lane_in : 0
// rst is asynchronous, active-high, and clears every register immediately.
// All outputs come straight from flops; no input reaches an output
// combinationally.
//
// Optional feature (macro PIPE_STAT_EN):
//   adds clr_stat input and stall_cnt / flush_cnt saturating counters.
//   stall_cnt counts edges with stall=1, flush=0, out_valid=1 (stalls that
//   actually hold a live instruction); flush_cnt counts edges with flush=1.
//   clr_stat zeroes both on the next edge and beats an increment.
//
// Ports:
//   clk, rst                    clock / async reset
//   stall, flush                stage control
//   in_valid, pc_in, lane_in    upstream slot (lane k at [k*DATA_W +: DATA_W])
//   out_valid, pc_out, lane_out registered stage contents
//   clr_stat, stall_cnt, flush_cnt   statistics (PIPE_STAT_EN only)
// ---------------------------------------------------------------------------

// One operand lane. Lanes share only the control decode; no data crosses
// between them.
module pipe_stage_lane #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_stall,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_q <= '0;
    else if (i_flush)  r_q <= '0;
    else if (!i_stall) r_q <= i_valid ? i_d : '0;  // bubbles carry zero operands
  end

  assign o_q = r_q;
endmodule

module pipe_stage_reg #(
  parameter int PC_W          = 16,
  parameter int DATA_W        = 32,
  parameter int NLANE         = 3,
  parameter bit FLUSH_KEEP_PC = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [PC_W-1:0]         pc_in,
  input  logic [NLANE*DATA_W-1:0] lane_in,
  output logic                    out_valid,
  output logic [PC_W-1:0]         pc_out,
  output logic [NLANE*DATA_W-1:0] lane_out
`ifdef PIPE_STAT_EN
  ,
  input  logic                    clr_stat,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
`endif
);

  logic                           r_valid;
  logic [PC_W-1:0]                r_pc;
  logic [NLANE-1:0][DATA_W-1:0]   w_lane_in;
  logic [NLANE-1:0][DATA_W-1:0]   w_lane_out;

  assign w_lane_in = lane_in;

  // Valid + PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      // Keeping the PC on a flush lets later stages see where the bubble sits.
      r_pc    <= FLUSH_KEEP_PC ? pc_in : '0;
    end else if (!stall) begin
      r_valid <= in_valid;
      r_pc    <= pc_in;
    end
  end

  // Operand lanes
  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    pipe_stage_lane #(.DATA_W(DATA_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_stall (stall),
      .i_valid (in_valid),
      .i_d     (w_lane_in[k]),
      .o_q     (w_lane_out[k])
    );
  end

  assign out_valid = r_valid;
  assign pc_out    = r_pc;
  assign lane_out  = w_lane_out;

`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_inc;

  // Only stalls that freeze a live instruction are interesting.
  assign w_stall_inc = stall && !flush && r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (clr_stat) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush && (r_flush_cnt != {CNT_W{1'b1}}))       r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. Two instances share the inputs:
//   dut  : defaults (FLUSH_KEEP_PC=1, CNT_W=16)
//   dut0 : FLUSH_KEEP_PC=0, CNT_W=4 (flush PC clear, counter saturation)
module tb_pipe_stage_reg;
  localparam int PC_W = 16, DATA_W = 32, NLANE = 3;

  logic                    clk = 1'b0;
  logic                    rst, stall, flush, in_valid;
  logic [PC_W-1:0]         pc_in;
  logic [NLANE*DATA_W-1:0] lane_in;
  logic                    ov, ov0;
  logic [PC_W-1:0]         pc, pc0;
  logic [NLANE*DATA_W-1:0] lo, lo0;
`ifdef PIPE_STAT_EN
  logic                    clr_stat;
  logic [15:0]             scnt, fcnt;
  logic [3:0]              scnt0, fcnt0;
`endif

  int npass = 0, ntot = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .pc_in(pc_in), .lane_in(lane_in), .out_valid(ov), .pc_out(pc), .lane_out(lo)
`ifdef PIPE_STAT_EN
    , .clr_stat(clr_stat), .stall_cnt(scnt), .flush_cnt(fcnt)
`endif
  );

  pipe_stage_reg #(.FLUSH_KEEP_PC(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .pc_in(pc_in), .lane_in(lane_in), .out_valid(ov0), .pc_out(pc0), .lane_out(lo0)
`ifdef PIPE_STAT_EN
    , .clr_stat(clr_stat), .stall_cnt(scnt0), .flush_cnt(fcnt0)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Check both instances' pipeline outputs; pc0_exp differs only on flush.
  task automatic chk_out(input string tag, input logic v, input logic [PC_W-1:0] p,
                         input logic [PC_W-1:0] p0, input logic [NLANE*DATA_W-1:0] l);
    check({tag, ".valid"}, ov, v);
    check({tag, ".pc"}, pc, p);
    check({tag, ".lanes"}, lo, l);
    check({tag, ".valid0"}, ov0, v);
    check({tag, ".pc0"}, pc0, p0);
    check({tag, ".lanes0"}, lo0, l);
  endtask

  localparam logic [NLANE*DATA_W-1:0] L_A = {32'h33, 32'h22, 32'h11};
  localparam logic [NLANE*DATA_W-1:0] L_B = {32'hA5A5A5A5, 32'h0, 32'hFFFFFFFF};

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    pc_in = '0; lane_in = '0;
`ifdef PIPE_STAT_EN
    clr_stat = 1'b0;
`endif
    // Async reset visible before any clock edge
    #1 rst = 1'b1;
    #1 chk_out("reset", 1'b0, 16'h0, 16'h0, '0);
`ifdef PIPE_STAT_EN
    check("reset.scnt", scnt, 0); check("reset.fcnt", fcnt, 0);
`endif
    #1 rst = 1'b0;

    // Load
    in_valid = 1'b1; pc_in = 16'h0040; lane_in = L_A;
    step();
    chk_out("load", 1'b1, 16'h0040, 16'h0040, L_A);

    // Stall 5 cycles with changing inputs
    stall = 1'b1; pc_in = 16'h0044;
    for (int i = 0; i < 5; i++) begin
      lane_in = {32'(i + 7), 32'(i + 8), 32'(i + 9)};
      step();
      chk_out("stall_hold", 1'b1, 16'h0040, 16'h0040, L_A);
    end
`ifdef PIPE_STAT_EN
    check("stall.scnt", scnt, 5); check("stall.scnt0", scnt0, 5);
`endif

    // Flush wins over stall
    flush = 1'b1; pc_in = 16'h0048; lane_in = L_B;
    step();
    chk_out("flush", 1'b0, 16'h0048, 16'h0000, '0);
`ifdef PIPE_STAT_EN
    check("flush.fcnt", fcnt, 1); check("flush.fcnt0", fcnt0, 1);
    check("flush.scnt", scnt, 5);
`endif

    // Stall over a bubble holds but is not counted
    flush = 1'b0; pc_in = 16'h0070;
    step();
    chk_out("stall_bubble", 1'b0, 16'h0048, 16'h0000, '0);
`ifdef PIPE_STAT_EN
    check("stall_bubble.scnt", scnt, 5);
`endif

    // Bubble load: in_valid=0 with nonzero lanes
    stall = 1'b0; in_valid = 1'b0; pc_in = 16'h004C; lane_in = L_B;
    step();
    chk_out("bubble", 1'b0, 16'h004C, 16'h004C, '0);

    // Lane independence with extreme values
    in_valid = 1'b1; pc_in = 16'h0060;
    step();
    chk_out("lanes_indep", 1'b1, 16'h0060, 16'h0060, L_B);

    // Async reset mid-stall
    stall = 1'b1; pc_in = 16'h0064; lane_in = L_A;
    step();
    chk_out("pre_rst_hold", 1'b1, 16'h0060, 16'h0060, L_B);
    #2 rst = 1'b1;
    #1 chk_out("rst_midstall", 1'b0, 16'h0, 16'h0, '0);
`ifdef PIPE_STAT_EN
    check("rst.scnt", scnt, 0); check("rst.fcnt", fcnt, 0);
`endif
    #2 rst = 1'b0; stall = 1'b0; in_valid = 1'b1; pc_in = 16'h0050; lane_in = L_A;
    step();
    chk_out("post_rst_load", 1'b1, 16'h0050, 16'h0050, L_A);

`ifdef PIPE_STAT_EN
    // Saturation and clear
    stall = 1'b1;
    repeat (20) step();
    check("sat.scnt", scnt, 20);
    check("sat.scnt0", scnt0, 15);
    clr_stat = 1'b1;
    step();
    check("clr.scnt", scnt, 0); check("clr.scnt0", scnt0, 0);
    clr_stat = 1'b0;
    step();
    check("after_clr.scnt0", scnt0, 1);
    stall = 1'b0;
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, width of one operand lane.
REQ-003 SHALL have parameter NLANE, default 3, number of operand lanes (lane 0 rs1, lane 1 rs2, lane 2 imm in the default pipeline).
REQ-004 SHALL have parameter FLUSH_KEEP_PC, default 1; 1 means pc_in is loaded on flush, 0 means pc_out clears to 0 on flush.
REQ-005 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 stall  input  1  hold the stage contents.
REQ-009 flush  input  1  replace the stage contents with a bubble (jump/branch taken).
REQ-010 in_valid  input  1  upstream slot holds a real instruction.
REQ-011 pc_in  input  PC_W  upstream PC.
REQ-012 lane_in  input  NLANE*DATA_W  packed operands; lane k occupies bits [k*DATA_W +: DATA_W].
REQ-013 out_valid  output  1  registered valid.
REQ-014 pc_out  output  PC_W  registered PC.
REQ-015 lane_out  output  NLANE*DATA_W  registered operands, packed as lane_in.
REQ-016 clr_stat  input  1  synchronous clear of the counters (present only with PIPE_STAT_EN).
REQ-017 stall_cnt, flush_cnt  output  CNT_W each  statistics counters (present only with PIPE_STAT_EN).

Function
REQ-018 All outputs SHALL be registered, with a latency of exactly 1 clk from input to output.
REQ-019 Per-edge priority SHALL be rst > flush > stall > load.
REQ-020 On flush: out_valid<=0, every lane<=0, pc_out<=pc_in when FLUSH_KEEP_PC=1, else pc_out<=0; this applies whatever the values of stall and in_valid.
REQ-021 On stall without flush: out_valid, pc_out and lane_out SHALL hold their values.
REQ-022 On load: out_valid<=in_valid and pc_out<=pc_in; lanes<=lane_in when in_valid=1, else lanes<=0.
REQ-023 Lanes SHALL be independent; no cross-lane arithmetic is performed.
REQ-024 A stall lasting any number of cycles SHALL NOT corrupt the held contents; the first load after stall deasserts takes the current inputs.
REQ-025 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-026 While rst=1: out_valid=0, pc_out=0, lane_out=0, and the counters (when present) = 0, with no clk edge required.
REQ-027 Reset asserted mid-stall or mid-flush SHALL override that operation immediately; the first clk edge after release performs a normal priority evaluation.

Configuration
REQ-028 The statistics feature SHALL be controlled by macro PIPE_STAT_EN.
REQ-029 With PIPE_STAT_EN defined, stall_cnt SHALL increment on each edge where stall=1, flush=0 and out_valid=1.
REQ-030 With PIPE_STAT_EN defined, flush_cnt SHALL increment on each edge where flush=1.
REQ-031 Both counters SHALL saturate at all-ones, and clr_stat=1 SHALL zero them on the next edge, with clr_stat taking priority over increment.
REQ-032 Without PIPE_STAT_EN, clr_stat, stall_cnt, flush_cnt and their registers SHALL be absent, and pipeline behaviour SHALL be identical in both builds.

Verification
REQ-033 Load: in_valid=1, pc_in=0x0040, lanes {0x11,0x22,0x33}, no stall/flush -> next edge out_valid=1, pc_out=0x0040, lanes {0x11,0x22,0x33}.
REQ-034 Stall hold: after REQ-033, stall=1 for 5 cycles while pc_in=0x0044 and lanes change -> outputs remain 0x0040/{0x11,0x22,0x33}; stall_cnt=5.
REQ-035 Flush wins: stall=1 and flush=1, pc_in=0x0048 -> out_valid=0, lanes=0, pc_out=0x0048 (FLUSH_KEEP_PC=1) or 0 (FLUSH_KEEP_PC=0); flush_cnt increments by 1 and stall_cnt is unchanged.
REQ-036 Bubble: in_valid=0 with lane_in nonzero -> out_valid=0, lanes=0, pc_out=pc_in.
REQ-037 Async reset: assert rst between edges during a stall -> all outputs 0 without waiting for an edge; release, load 0x0050 -> out_valid=1, pc_out=0x0050.
REQ-038 Saturation: CNT_W=4, stall held 20 cycles -> stall_cnt=15; clr_stat=1 with stall=1 -> stall_cnt=0 the next edge.
